// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter that shares one crossbar slave port among MASTERS
// requesters. Each grant runs one complete req/ack/resp transaction. A per-state
// watchdog turns a stalled slave into an error response so no master can hang.
// All outputs come straight from registers.
module xbar_slave_arbiter #(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MASTERS-1:0]        m_req,
  input  logic [MASTERS-1:0]        m_cmd,
  input  logic [MASTERS*ADDR_W-1:0] m_addr,
  input  logic [MASTERS*DATA_W-1:0] m_wdata,
  output logic [MASTERS-1:0]        m_ack,
  output logic [MASTERS-1:0]        m_resp,
  output logic                      m_err,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      s_req,
  output logic                      s_cmd,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic                      s_ack,
  input  logic                      s_resp,
  input  logic [DATA_W-1:0]         s_rdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(MASTERS);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;

  // Control state
  logic [1:0]         state_q,  state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q,  grant_d;
  logic [TMR_W-1:0]   timer_q,  timer_d;

  // Registered outputs
  logic [MASTERS-1:0] m_ack_q,   m_ack_d;
  logic [MASTERS-1:0] m_resp_q,  m_resp_d;
  logic               m_err_q,   m_err_d;
  logic [DATA_W-1:0]  m_rdata_q, m_rdata_d;
  logic               s_req_q,   s_req_d;
  logic               s_cmd_q,   s_cmd_d;
  logic [ADDR_W-1:0]  s_addr_q,  s_addr_d;
  logic [DATA_W-1:0]  s_wdata_q, s_wdata_d;
  logic               busy_q,    busy_d;

  // Arbitration and helper signals
  logic               hit;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;
  logic               sel_cmd;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [MASTERS-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_nxt;
  logic [TMR_W-1:0]   timer_inc;
  logic               timeout;

  assign m_ack   = m_ack_q;
  assign m_resp  = m_resp_q;
  assign m_err   = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_req   = s_req_q;
  assign s_cmd   = s_cmd_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign busy    = busy_q;

  // Round-robin search: scan m_req starting at rr_ptr, wrapping; first set bit wins.
  // MASTERS is a power of two, so the index addition wraps naturally.
  always_comb begin
    hit  = 1'b0;
    win  = rr_ptr_q;
    cand = rr_ptr_q;
    for (int k = 0; k < MASTERS; k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (!hit && m_req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  // Select the winner's command, address and write data.
  always_comb begin
    sel_cmd   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < MASTERS; k++) begin
      if (win == IDX_W'(k)) begin
        sel_cmd   = m_cmd[k];
        sel_addr  = m_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = m_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // One-hot view of the current grant, and the pointer value used on exit to IDLE.
  always_comb begin
    grant_oh = '0;
    for (int k = 0; k < MASTERS; k++) begin
      grant_oh[k] = (grant_q == IDX_W'(k));
    end
    grant_nxt = grant_q + IDX_W'(1);
  end

  // Saturating wait timer; timeout fires on the cycle the count would reach TIMEOUT,
  // so the error pulse lands exactly TIMEOUT cycles after entering the wait state.
  always_comb begin
    timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    timeout   = (timer_inc == TMR_MAX);
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    timer_d   = timer_q;
    m_ack_d   = '0;
    m_resp_d  = '0;
    m_err_d   = 1'b0;
    m_rdata_d = m_rdata_q;
    s_req_d   = 1'b0;
    s_cmd_d   = s_cmd_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;

    case (state_q)
      S_IDLE: begin
        // Stray s_ack/s_resp are ignored here.
        if (hit) begin
          grant_d  = win;
          s_req_d  = 1'b1;
          s_cmd_d  = sel_cmd;
          s_addr_d = sel_addr;
          if (sel_cmd) begin
            s_wdata_d = sel_wdata;
          end
          timer_d  = '0;
          state_d  = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        // s_resp without s_ack is ignored; s_ack wins over a same-cycle timeout.
        if (s_ack) begin
          m_ack_d = grant_oh;
          timer_d = '0;
          if (s_resp) begin
            // Response arrived together with the ack: finish now.
            m_resp_d  = grant_oh;
            m_rdata_d = s_rdata;
            m_err_d   = 1'b0;
            rr_ptr_d  = grant_nxt;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAIT_RESP;
          end
        end else if (timeout) begin
          m_ack_d   = grant_oh;
          m_resp_d  = grant_oh;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
          rr_ptr_d  = grant_nxt;
          timer_d   = timer_inc;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      S_WAIT_RESP: begin
        if (s_resp) begin
          m_resp_d  = grant_oh;
          m_rdata_d = s_rdata;
          m_err_d   = 1'b0;
          rr_ptr_d  = grant_nxt;
          state_d   = S_IDLE;
        end else if (timeout) begin
          m_resp_d  = grant_oh;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
          rr_ptr_d  = grant_nxt;
          timer_d   = timer_inc;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything, abandoning any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      timer_q   <= '0;
      m_ack_q   <= '0;
      m_resp_q  <= '0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
      s_req_q   <= 1'b0;
      s_cmd_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      timer_q   <= timer_d;
      m_ack_q   <= m_ack_d;
      m_resp_q  <= m_resp_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      s_req_q   <= s_req_d;
      s_cmd_q   <= s_cmd_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter: read, round-robin fairness, write,
// ack/resp timeouts, reset mid-transaction and simultaneous ack+resp.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_xbar_slave_arbiter;

  localparam int MASTERS = 4;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [MASTERS-1:0]        m_req;
  logic [MASTERS-1:0]        m_cmd;
  logic [MASTERS*ADDR_W-1:0] m_addr;
  logic [MASTERS*DATA_W-1:0] m_wdata;
  logic [MASTERS-1:0]        m_ack;
  logic [MASTERS-1:0]        m_resp;
  logic                      m_err;
  logic [DATA_W-1:0]         m_rdata;
  logic                      s_req;
  logic                      s_cmd;
  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_wdata;
  logic                      s_ack;
  logic                      s_resp;
  logic [DATA_W-1:0]         s_rdata;
  logic                      busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] exp_addr [MASTERS];

  xbar_slave_arbiter #(
    .MASTERS (MASTERS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_cmd   (m_cmd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_resp  (m_resp),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_cmd   (s_cmd),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ack   (s_ack),
    .s_resp  (s_resp),
    .s_rdata (s_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_master(input int i, input logic cmd, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] wd);
    m_cmd[i]                     = cmd;
    m_addr[i*ADDR_W +: ADDR_W]   = a;
    m_wdata[i*DATA_W +: DATA_W]  = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt_resp;
    int cnt_busy;

    rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    exp_addr[0] = 30'h100; exp_addr[1] = 30'h101;
    exp_addr[2] = 30'h1234; exp_addr[3] = 30'h103;
    for (int i = 0; i < MASTERS; i++) set_master(i, 1'b0, exp_addr[i], 32'h1111 * (i + 1));

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_sreq", s_req, 0);
    chk("rst_mack", m_ack, 0);
    chk("rst_mresp", m_resp, 0);
    chk("rst_merr", m_err, 0);
    chk("rst_saddr", s_addr, 0);
    rst = 1'b0;

    // Single read from master 2
    m_req = 4'b0100;
    tick();
    chk("rd_sreq", s_req, 1);
    chk("rd_saddr", s_addr, 30'h1234);
    chk("rd_scmd", s_cmd, 0);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_sreq_once", s_req, 0);
    tick();
    chk("rd_noack", m_ack, 0);
    s_ack = 1'b1;
    tick();
    chk("rd_mack", m_ack, 4'b0100);
    s_ack = 1'b0; m_req = '0;
    tick();
    chk("rd_mack_once", m_ack, 0);
    chk("rd_noresp", m_resp, 0);
    tick();
    s_resp = 1'b1; s_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_mresp", m_resp, 4'b0100);
    chk("rd_rdata", m_rdata, 32'hDEADBEEF);
    chk("rd_merr", m_err, 0);
    chk("rd_busy_low", busy, 0);
    s_resp = 1'b0; s_rdata = '0;

    // Pointer now 3: masters 0,2,3 requesting must pick 3
    m_req = 4'b1101;
    tick();
    chk("rr3_sreq", s_req, 1);
    chk("rr3_saddr", s_addr, 30'h103);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0;
    chk("rr3_mack", m_ack, 4'b1000);
    s_resp = 1'b1; s_rdata = 32'h33;
    tick();
    s_resp = 1'b0;
    chk("rr3_mresp", m_resp, 4'b1000);

    // Fairness: all request, zero-latency slave, back-to-back issue
    m_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      int g;
      g = k % MASTERS;
      tick();
      chk($sformatf("fair%0d_sreq", k), s_req, 1);
      chk($sformatf("fair%0d_saddr", k), s_addr, exp_addr[g]);
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      chk($sformatf("fair%0d_mack", k), m_ack, 4'b0001 << g);
      s_resp = 1'b1; s_rdata = 32'h1000 + k;
      tick();
      s_resp = 1'b0;
      chk($sformatf("fair%0d_mresp", k), m_resp, 4'b0001 << g);
      chk($sformatf("fair%0d_rdata", k), m_rdata, 32'h1000 + k);
    end

    // Write from master 1 (pointer is 0 after fairness)
    set_master(1, 1'b1, 30'h101, 32'hA5A5A5A5);
    m_req = 4'b0010;
    tick();
    chk("wr_sreq", s_req, 1);
    chk("wr_scmd", s_cmd, 1);
    chk("wr_swdata", s_wdata, 32'hA5A5A5A5);
    chk("wr_saddr", s_addr, 30'h101);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0;
    chk("wr_mack", m_ack, 4'b0010);
    s_resp = 1'b1; s_rdata = 32'h5555;
    tick();
    s_resp = 1'b0;
    chk("wr_mresp", m_resp, 4'b0010);
    chk("wr_merr", m_err, 0);

    // Ack timeout: master 0 read, slave silent
    m_req = 4'b0001;
    tick();
    chk("ato_sreq", s_req, 1);
    chk("ato_swdata_kept", s_wdata, 32'hA5A5A5A5);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      chk($sformatf("ato_early%0d", i), m_ack, 0);
    end
    chk("ato_busy_before", busy, 1);
    tick();
    chk("ato_mack", m_ack, 4'b0001);
    chk("ato_mresp", m_resp, 4'b0001);
    chk("ato_merr", m_err, 1);
    chk("ato_rdata", m_rdata, 0);
    chk("ato_busy", busy, 0);
    m_req = '0;

    // Resp timeout: pointer 1, master 1 read
    set_master(1, 1'b0, 30'h101, 32'h2222);
    m_req = 4'b0010;
    tick();
    chk("rto_sreq", s_req, 1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0; s_rdata = 32'hBAD;
    chk("rto_mack", m_ack, 4'b0010);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      chk($sformatf("rto_early%0d", i), m_resp, 0);
    end
    tick();
    chk("rto_mresp", m_resp, 4'b0010);
    chk("rto_merr", m_err, 1);
    chk("rto_rdata", m_rdata, 0);
    chk("rto_busy", busy, 0);
    s_rdata = '0;

    // Reset in the middle of WAIT_RESP: pointer 2, master 2
    m_req = 4'b0100;
    tick();
    chk("rrs_sreq", s_req, 1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0;
    chk("rrs_mack", m_ack, 4'b0100);
    tick();
    rst = 1'b1; s_resp = 1'b1; s_rdata = 32'h77;
    tick();
    chk("rrs_busy", busy, 0);
    chk("rrs_sreq0", s_req, 0);
    chk("rrs_scmd", s_cmd, 0);
    chk("rrs_saddr", s_addr, 0);
    chk("rrs_swdata", s_wdata, 0);
    chk("rrs_mack0", m_ack, 0);
    chk("rrs_mresp0", m_resp, 0);
    chk("rrs_merr", m_err, 0);
    chk("rrs_rdata", m_rdata, 0);
    rst = 1'b0; s_resp = 1'b0;
    cnt_resp = 0;
    cnt_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin s_ack = 1'b1; s_resp = 1'b1; end
      else begin s_ack = 1'b0; s_resp = 1'b0; end
      tick();
      if (m_resp != 0) cnt_resp++;
      if (busy) cnt_busy++;
    end
    s_ack = 1'b0; s_resp = 1'b0;
    chk("rrs_no_resp", cnt_resp, 0);
    chk("rrs_idle", cnt_busy, 0);

    // Simultaneous ack+resp: pointer 0, masters 0 and 1 requesting
    set_master(0, 1'b0, 30'h100, 32'h0);
    m_req = 4'b0011;
    tick();
    chk("sim_sreq", s_req, 1);
    chk("sim_saddr", s_addr, 30'h100);
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hC0FFEE;
    tick();
    chk("sim_mack", m_ack, 4'b0001);
    chk("sim_mresp", m_resp, 4'b0001);
    chk("sim_rdata", m_rdata, 32'hC0FFEE);
    chk("sim_merr", m_err, 0);
    chk("sim_gap", s_req, 0);
    s_ack = 1'b0; s_resp = 1'b0; m_req = 4'b0010;
    tick();
    chk("sim_next_sreq", s_req, 1);
    chk("sim_next_saddr", s_addr, 30'h101);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; m_req = '0;
    chk("sim_next_mack", m_ack, 4'b0010);
    s_resp = 1'b1; s_rdata = 32'h99;
    tick();
    s_resp = 1'b0;
    chk("sim_next_mresp", m_resp, 4'b0010);
    chk("sim_next_rdata", m_rdata, 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
